// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_pkg
// Purpose : Shared types and the read-source selection helper for the
//           multi-port register file.
// Revision: 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    // Clear-sweep controller states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } clr_state_t;

    // Where a read port takes its data from this cycle
    typedef enum logic [1:0] {
        SRC_ARRAY = 2'd0,
        SRC_WD0   = 2'd1,
        SRC_WD1   = 2'd2,
        SRC_ZERO  = 2'd3
    } rd_src_t;

    // Zero cases dominate, then the priority write port, then port 0, then storage.
    function automatic rd_src_t rd_src_sel(
        input logic oob,
        input logic zero_hit,
        input logic hit1,
        input logic hit0
    );
        if (oob || zero_hit) return SRC_ZERO;
        else if (hit1)       return SRC_WD1;
        else if (hit0)       return SRC_WD0;
        else                 return SRC_ARRAY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_mp_rf_read_port.sv
`default_nettype none
// ============================================================================
// Module  : rf_read_port
// Purpose : One read port: array mux, write-to-read bypass, zero-R0 masking
//           and an optional output register.
// Revision: 1.0 - initial release
// ============================================================================
module rf_read_port #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int READ_LAT = 0,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AW-1:0]           i_ra,
    input  logic [DEPTH*DATA_W-1:0] i_mem_flat,
    input  logic                    i_byp_en0,
    input  logic [AW-1:0]           i_byp_wa0,
    input  logic [DATA_W-1:0]       i_byp_wd0,
    input  logic                    i_byp_en1,
    input  logic [AW-1:0]           i_byp_wa1,
    input  logic [DATA_W-1:0]       i_byp_wd1,
    output logic [DATA_W-1:0]       o_rd
);
    import reg_file_pkg::*;

    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic              w_oob;
    logic              w_zero_hit;
    logic              w_hit0;
    logic              w_hit1;
    rd_src_t           w_src;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_rd;

    // Bypass enables arrive already qualified (legal address, not busy).
    assign w_oob      = ({1'b0, i_ra} >= c_DEPTH);
    assign w_zero_hit = (ZERO_R0 != 0) && (i_ra == '0);
    assign w_hit1     = (BYPASS != 0) && i_byp_en1 && (i_byp_wa1 == i_ra);
    assign w_hit0     = (BYPASS != 0) && i_byp_en0 && (i_byp_wa0 == i_ra);
    assign w_src      = rd_src_sel(w_oob, w_zero_hit, w_hit1, w_hit0);

    // Storage word selected by the read address (stays 0 when out of range)
    always_comb begin
        w_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_ra == AW'(i)) w_word = i_mem_flat[i*DATA_W +: DATA_W];
        end
    end

    // Final read data source selection
    always_comb begin
        w_rd = '0;
        case (w_src)
            SRC_WD1:   w_rd = i_byp_wd1;
            SRC_WD0:   w_rd = i_byp_wd0;
            SRC_ARRAY: w_rd = w_word;
            default:   w_rd = '0;
        endcase
    end

    generate
        if (READ_LAT != 0) begin : g_reg_out
            logic [DATA_W-1:0] r_rd;
            // Registered read: data follows the address by one clock
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) r_rd <= '0;
                else      r_rd <= w_rd;
            end
            assign o_rd = r_rd;
        end else begin : g_comb_out
            logic w_unused_clk;
            assign w_unused_clk = clk ^ rst;
            assign o_rd = w_rd;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_mp
// Purpose : Parametrised multi-port register file with two prioritised write
//           ports, NREAD read ports and a hardware clear sweep.
//           rst is asynchronous and active-low.
// Revision: 1.0 - initial release
// ============================================================================
module reg_file_mp #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int NREAD    = 2,
    parameter int READ_LAT = 0,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we0,
    input  logic [AW-1:0]           wa0,
    input  logic [DATA_W-1:0]       wd0,
    input  logic                    we1,
    input  logic [AW-1:0]           wa1,
    input  logic [DATA_W-1:0]       wd1,
    input  logic [NREAD*AW-1:0]     ra,
    output logic [NREAD*DATA_W-1:0] rd,
    input  logic                    clr_req,
    output logic                    busy
);
    import reg_file_pkg::*;

    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_LAST  = (AW+1)'(DEPTH - 1);

    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic [DEPTH*DATA_W-1:0] w_mem_flat;
    clr_state_t              r_state;
    logic [AW:0]             r_idx;
    logic                    r_busy;
    logic                    w_we0_ok;
    logic                    w_we1_ok;

    // A write lands only when idle, in range and not aimed at a hard-wired R0.
    assign w_we0_ok = we0 && !r_busy && ({1'b0, wa0} < c_DEPTH)
                      && !((ZERO_R0 != 0) && (wa0 == '0));
    assign w_we1_ok = we1 && !r_busy && ({1'b0, wa1} < c_DEPTH)
                      && !((ZERO_R0 != 0) && (wa1 == '0));
    assign busy     = r_busy;

    // Storage: sweep clears one entry per cycle, otherwise port 1 overrides port 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (r_state == ST_SWEEP) begin
            r_mem[r_idx[AW-1:0]] <= '0;
        end else begin
            if (w_we0_ok) r_mem[wa0] <= wd0;
            if (w_we1_ok) r_mem[wa1] <= wd1;
        end
    end

    // Clear controller: busy spans exactly DEPTH cycles starting after clr_req
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr_req) begin
                        r_state <= ST_SWEEP;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (r_idx == c_LAST) begin
                        r_state <= ST_IDLE;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx <= r_idx + (AW+1)'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_flat
            assign w_mem_flat[i*DATA_W +: DATA_W] = r_mem[i];
        end

        for (genvar k = 0; k < NREAD; k++) begin : g_rd_port
            rf_read_port #(
                .DATA_W   (DATA_W),
                .DEPTH    (DEPTH),
                .AW       (AW),
                .READ_LAT (READ_LAT),
                .BYPASS   (BYPASS),
                .ZERO_R0  (ZERO_R0)
            ) u_port (
                .clk        (clk),
                .rst        (rst),
                .i_ra       (ra[k*AW +: AW]),
                .i_mem_flat (w_mem_flat),
                .i_byp_en0  (w_we0_ok),
                .i_byp_wa0  (wa0),
                .i_byp_wd0  (wd0),
                .i_byp_en1  (w_we1_ok),
                .i_byp_wa1  (wa1),
                .i_byp_wd1  (wd1),
                .o_rd       (rd[k*DATA_W +: DATA_W])
            );
        end
    endgenerate

endmodule
`default_nettype wire
